// File: rtl/lcd_write_arbiter.sv
// Shares one 9-bit LCD write driver between the init, show_char and show_pic clients.
// Define LCD_ARB_TIMEOUT_EN to add a per-grant watchdog that drives err_timeout.
module lcd_write_arbiter #(
  parameter logic [15:0] POR_CYCLES  = 16'd10,
  parameter logic [3:0]  GAP_CYCLES  = 4'd2,
  parameter logic [23:0] TIMEOUT_CYC = 24'd10_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  output logic       init_start,
  input  logic [8:0] init_data,
  input  logic       en_write_init,
  input  logic       init_done,
  output logic       init_wr_done,
  input  logic       req_char,
  output logic       show_char_flag,
  input  logic [8:0] show_char_data,
  input  logic       en_write_show_char,
  input  logic       show_char_done,
  output logic       char_wr_done,
  input  logic       req_pic,
  output logic       show_pic_flag,
  input  logic [8:0] show_pic_data,
  input  logic       en_write_show_pic,
  input  logic       show_pic_done,
  output logic       pic_wr_done,
  input  logic       wr_done,
  output logic [8:0] data,
  output logic       en_write,
  output logic       busy,
  output logic [1:0] grant,
  output logic       err_timeout
);

  localparam logic [1:0] GrNone = 2'b00;
  localparam logic [1:0] GrInit = 2'b01;
  localparam logic [1:0] GrChar = 2'b10;
  localparam logic [1:0] GrPic  = 2'b11;

  typedef enum logic [2:0] {
    StPor, StInitGo, StInit, StGap, StIdle, StChar, StPic
  } state_e;

  state_e      state_q;
  logic [15:0] por_cnt_q;
  logic [3:0]  gap_cnt_q;
  logic        pend_char_q, pend_pic_q;
  logic        last_pic_q;
  logic        init_start_q, char_flag_q, pic_flag_q, busy_q;
  logic [1:0]  grant_q;
  logic        cur_done, tmo_hit, pick_char, pick_pic;

  // Routing follows the registered grant, so wr_done passes through with no latency.
  always_comb begin
    data         = 9'h000;
    en_write     = 1'b0;
    init_wr_done = 1'b0;
    char_wr_done = 1'b0;
    pic_wr_done  = 1'b0;
    cur_done     = 1'b0;
    case (grant_q)
      GrInit: begin
        data         = init_data;
        en_write     = en_write_init;
        init_wr_done = wr_done;
        cur_done     = init_done;
      end
      GrChar: begin
        data         = show_char_data;
        en_write     = en_write_show_char;
        char_wr_done = wr_done;
        cur_done     = show_char_done;
      end
      GrPic: begin
        data         = show_pic_data;
        en_write     = en_write_show_pic;
        pic_wr_done  = wr_done;
        cur_done     = show_pic_done;
      end
      default: ;
    endcase
  end

  // Round-robin: with both pending, serve the client that was not served last.
  assign pick_char = pend_char_q & (~pend_pic_q | last_pic_q);
  assign pick_pic  = pend_pic_q & ~pick_char;

`ifdef LCD_ARB_TIMEOUT_EN
  logic [23:0] tmo_cnt_q;
  logic        err_q;

  assign tmo_hit = (grant_q != GrNone) && (tmo_cnt_q == TIMEOUT_CYC - 24'd1) && !cur_done;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= (grant_q == GrNone) ? 24'd0 : tmo_cnt_q + 24'd1;
      if (tmo_hit) err_q <= 1'b1;
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign tmo_hit            = 1'b0;
  assign err_timeout        = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= StPor;
      por_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      pend_char_q  <= 1'b0;
      pend_pic_q   <= 1'b0;
      last_pic_q   <= 1'b1;
      init_start_q <= 1'b0;
      char_flag_q  <= 1'b0;
      pic_flag_q   <= 1'b0;
      busy_q       <= 1'b0;
      grant_q      <= GrNone;
    end else begin
      init_start_q <= 1'b0;
      char_flag_q  <= 1'b0;
      pic_flag_q   <= 1'b0;
      unique case (state_q)
        StPor: begin
          busy_q <= 1'b1;
          if (por_cnt_q == POR_CYCLES - 16'd1) begin
            state_q      <= StInitGo;
            init_start_q <= 1'b1;
          end else begin
            por_cnt_q <= por_cnt_q + 16'd1;
          end
        end
        StInitGo: begin
          state_q <= StInit;
          grant_q <= GrInit;
        end
        StInit, StChar, StPic: begin
          if (cur_done || tmo_hit) begin
            state_q   <= StGap;
            grant_q   <= GrNone;
            gap_cnt_q <= '0;
            if (tmo_hit && state_q == StChar) pend_char_q <= 1'b0;
            if (tmo_hit && state_q == StPic)  pend_pic_q  <= 1'b0;
          end
        end
        StGap: begin
          if (gap_cnt_q == GAP_CYCLES - 4'd1) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 4'd1;
          end
        end
        StIdle: begin
          if (pick_char) begin
            state_q     <= StChar;
            grant_q     <= GrChar;
            char_flag_q <= 1'b1;
            pend_char_q <= 1'b0;
            last_pic_q  <= 1'b0;
            busy_q      <= 1'b1;
          end else if (pick_pic) begin
            state_q    <= StPic;
            grant_q    <= GrPic;
            pic_flag_q <= 1'b1;
            pend_pic_q <= 1'b0;
            last_pic_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        default: state_q <= StPor;
      endcase
      // Placed last so a same-cycle request beats any clear above.
      if (req_char) pend_char_q <= 1'b1;
      if (req_pic)  pend_pic_q  <= 1'b1;
    end
  end

  assign init_start     = init_start_q;
  assign show_char_flag = char_flag_q;
  assign show_pic_flag  = pic_flag_q;
  assign busy           = busy_q;
  assign grant          = grant_q;

endmodule
